// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;
    localparam int ARB_WAIT_W     = 4;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_MAX_WAIT   = 4;

    typedef enum logic {
        S_RUN,
        S_HALTED
    } arb_state_t;
endpackage

// File: rtl/arb_wait_counter.sv
// Saturating wait counter: clear has priority over increment, holds at MAX_WAIT.
module arb_wait_counter
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc_i,
    input  logic                  clr_i,
    output logic [ARB_WAIT_W-1:0] cnt_o,
    output logic                  at_max_o
);
    localparam logic [ARB_WAIT_W-1:0] LIMIT = ARB_WAIT_W'(MAX_WAIT);

    logic [ARB_WAIT_W-1:0] cnt_q, cnt_d;

    assign at_max_o = (cnt_q == LIMIT);
    assign cnt_o    = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && !at_max_o)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data RAM between the core load/store path and the host port,
// with host-driven halt and a bounded host wait.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_WAIT   = DEF_MAX_WAIT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic [DATA_WIDTH-1:0] core_rdata,
    output logic                  core_stall,
    input  logic                  host_valid,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_ready,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  host_rvalid,
    input  logic                  halt_req,
    output logic                  halted,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_wr_en,
    input  logic [DATA_WIDTH-1:0] ram_dout
);
    arb_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] host_rdata_q, host_rdata_d;
    logic                  host_rvalid_q, host_rvalid_d;
    logic                  host_gnt, core_gnt, wait_max;
    logic [ARB_WAIT_W-1:0] wait_cnt;

    assign halted = (state_q == S_HALTED);

    // Core wins contention until the host has lost MAX_WAIT times in a row.
    assign host_gnt = host_valid & (halted | ~core_req | wait_max);
    assign core_gnt = core_req & ~halted & ~host_gnt;

    assign core_stall = halted | (core_req & ~core_gnt);
    assign host_ready = host_gnt;
    assign core_rdata = ram_dout;

    always_comb begin
        ram_addr  = core_addr;
        ram_din   = core_wdata;
        ram_wr_en = 1'b0;
        if (host_gnt) begin
            ram_addr  = host_addr;
            ram_din   = host_wdata;
            ram_wr_en = host_we;
        end else if (core_gnt) begin
            ram_wr_en = core_we;
        end
    end

    arb_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait (
        .clk      (clk),
        .rst      (rst),
        .inc_i    (host_valid & ~host_gnt),
        .clr_i    (host_gnt | ~host_valid),
        .cnt_o    (wait_cnt),
        .at_max_o (wait_max)
    );

    always_comb begin
        state_d       = halt_req ? S_HALTED : S_RUN;
        host_rvalid_d = host_gnt & ~host_we;
        host_rdata_d  = host_rdata_q;
        if (host_gnt && !host_we)
            host_rdata_d = ram_dout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_RUN;
            host_rdata_q  <= '0;
            host_rvalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            host_rdata_q  <= host_rdata_d;
            host_rvalid_q <= host_rvalid_d;
        end
    end

    assign host_rdata  = host_rdata_q;
    assign host_rvalid = host_rvalid_q;
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter and run/halt controller that shares the single-port data RAM between the single-cycle RISC-V core's load/store path and an external host port used for program/data loading and debug readback. Sits between the core's ALU-address / register-operand2 data path and the `ram` instance. It grants one requester per cycle and stalls the core (PC and register write frozen) whenever the core loses arbitration or is halted by the host. A bounded wait counter prevents host starvation.

## Interface
- `ADDR_WIDTH`, default 32: address width on all ports.
- `DATA_WIDTH`, default 32: data width on all ports.
- `MAX_WAIT`, default 4: number of cycles a pending host request may lose to the core before it is forced through. Legal range 1..15.

- `clk`  in  1  system clock. Single clock domain.
- `rst`  in  1  reset. Synchronous and active-high.
- `core_req`  in  1  core performs a memory access this cycle (load or store).
- `core_we`  in  1  core access is a store.
- `core_addr`  in  ADDR_WIDTH  core address (ALU output).
- `core_wdata`  in  DATA_WIDTH  core store data (register operand 2).
- `core_rdata`  out  DATA_WIDTH  load data, equal to `ram_dout`.
- `core_stall`  out  1  core must hold PC and suppress register and RAM writes this cycle.
- `host_valid`  in  1  host request pending.
- `host_we`  in  1  host request is a write.
- `host_addr`  in  ADDR_WIDTH  host address.
- `host_wdata`  in  DATA_WIDTH  host write data.
- `host_ready`  out  1  host request accepted this cycle.
- `host_rdata`  out  DATA_WIDTH  registered host read data.
- `host_rvalid`  out  1  `host_rdata` valid. One-cycle pulse.
- `halt_req`  in  1  level input; the host requests that the core be frozen.
- `halted`  out  1  the core is frozen.
- `ram_addr`  out  ADDR_WIDTH  address to the RAM.
- `ram_din`  out  DATA_WIDTH  write data to the RAM.
- `ram_wr_en`  out  1  RAM write enable.
- `ram_dout`  in  DATA_WIDTH  combinational RAM read data.

## Operation
**FSM states:** `S_RUN` and `S_HALTED`, registered.
- `S_RUN` → `S_HALTED` at the clock edge where `halt_req` = 1.
- `S_HALTED` → `S_RUN` at the clock edge where `halt_req` = 0.
- `halted` = (state == `S_HALTED`).

**Grant rule.** Combinational, evaluated every cycle:
- `host_gnt` = `host_valid` & (`halted` | !`core_req` | `wait_cnt` == `MAX_WAIT`).
- `core_gnt` = `core_req` & !`halted` & !`host_gnt`.
- When `host_valid` and `core_req` are both high and `wait_cnt` < `MAX_WAIT`, the core wins.

**Outputs derived from the grant:**
- `core_stall` = `halted` | (`core_req` & !`core_gnt`). While halted, the stall is unconditional.
- `host_ready` = `host_gnt`.
- RAM mux:
  - When `host_gnt`: the host address, data and write enable drive the RAM.
  - Else when `core_gnt`: the core address, data and write enable drive the RAM.
  - Otherwise: `ram_wr_en` = 0 and the address/data outputs are driven from the core inputs.
- `ram_wr_en` is never 1 for a stalled requester.
- `core_rdata` = `ram_dout` at all times. It is only meaningful when `core_gnt`.

**wait_cnt.** 4-bit register.
- Increments when `host_valid` & !`host_gnt`, saturating at `MAX_WAIT`.
- Clears to 0 when `host_gnt` or when !`host_valid`.

**Host read.** A granted host read (`host_gnt` & !`host_we`) captures `ram_dout` into `host_rdata`. `host_rvalid` pulses high in the following cycle. Host writes produce no `host_rvalid`.

## Timing
**Reset values:** state `S_RUN`, `wait_cnt` 0, `host_rdata` 0, `host_rvalid` 0. Therefore `halted` = 0 after reset. The combinational outputs follow the inputs from the first cycle after reset.

**Latency:**
- Core access: zero added cycles when granted.
- Host write: completes at the edge where `host_ready` = 1.
- Host read: data is available one cycle after acceptance.

**Worst-case host wait:** `MAX_WAIT` cycles of loss, then grant on the next cycle, i.e. `MAX_WAIT`+1 cycles from first assertion.

**Handshake:**
- The host must hold `host_valid` and its fields stable until `host_ready` is seen.
- Back-to-back host requests are accepted every cycle when the core is idle or halted.

**Halt timing:**
- `halt_req` rising → `halted` = 1 one cycle later. The core access in the assertion cycle still completes.
- `halt_req` falling → the core resumes one cycle later.

**Reset mid-operation:** a pending `host_rvalid` is cleared and an in-flight read is dropped. The host must reissue the request.

## Structure
- Shared package `dmem_arb_pkg` contains:
  - `arb_state_t` enum {`S_RUN`, `S_HALTED`};
  - `ARB_WAIT_W` = 4;
  - the default width constants.
- One sub-module, `arb_wait_counter` (saturating counter with inc/clr, width `ARB_WAIT_W`, limit `MAX_WAIT`).
- The grant logic, mux, read register and FSM live in `dmem_arbiter`. Target size is about 150–250 lines.

## Test plan
1. **Idle host, core traffic.** Core stores 0xDEADBEEF to 0x10, then loads 0x10 → `core_stall` always 0 and `core_rdata` = 0xDEADBEEF.
2. **Host only.** Host writes 0x12345678 to 0x20, then reads 0x20 → `host_ready` = 1 on each request and `host_rvalid` = 1 one cycle later with `host_rdata` = 0x12345678.
3. **Contention.** Core holds `core_req` = 1 continuously while the host asserts `host_valid` with `MAX_WAIT` = 4 → the host is granted on the 5th cycle, `core_stall` = 1 in exactly that cycle, then `wait_cnt` returns to 0.
4. **Halt.** Assert `halt_req`, perform 3 host writes on consecutive cycles, then deassert → `halted` = 1 from the cycle after assertion and `core_stall` = 1 throughout, including with `core_req` = 0. All three writes are accepted in 3 cycles, and the core resumes one cycle after deassertion.
5. **Reset mid-read.** A host read is accepted, and `rst` = 1 on the next edge → `host_rvalid` stays 0, `halted` = 0 and `wait_cnt` = 0.
